// File: rtl/nn_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nn_load_scheduler
// Purpose  : Sequences one inference. UART bytes are assembled into 24-bit
//            pixel packets, checked, and written to the image RAM. A full
//            image hands the RAM to the CPU and releases it from reset. When
//            the CPU halts, its result is sent back as an ASCII digit.
// Ports    : clk, rst (async, active-low)
//            rx_valid/rx_byte            - UART receive strobe and byte
//            cpu_ram_addr/data/we        - CPU side of the RAM port
//            ram_addr/ram_data_in/ram_we - arbitrated RAM port
//            cpu_run                     - CPU held in reset while low
//            cpu_halt/nn_result          - CPU completion and answer
//            tx_start/tx_byte/tx_busy    - UART transmit handshake
//            count_packets/err_count     - accepted / rejected packet counts
//            receive_done/send_done      - image loaded / result sent
// Revision : 1.0 - initial release
// ============================================================================
module nn_load_scheduler #(
  parameter int          NUM_PIXELS = 784,
  parameter logic [13:0] IMG_BASE   = 14'h0000,
  parameter logic [15:0] TIMEOUT    = 16'd4000,
  parameter logic [2:0]  HEADER     = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic [13:0] cpu_ram_addr,
  input  logic [23:0] cpu_ram_data,
  input  logic [3:0]  cpu_ram_we,
  output logic [13:0] ram_addr,
  output logic [23:0] ram_data_in,
  output logic [3:0]  ram_we,
  output logic        cpu_run,
  input  logic        cpu_halt,
  input  logic [3:0]  nn_result,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  output logic [31:0] count_packets,
  output logic [15:0] err_count,
  output logic        receive_done,
  output logic        send_done
);

  localparam logic [31:0] C_NUM_PIXELS = 32'(NUM_PIXELS);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT_TX = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;
  logic [15:0] r_tmo;
  logic [13:0] r_ld_addr;
  logic [23:0] r_ld_data;
  logic [3:0]  r_ld_we;
  logic        r_cpu_run;
  logic        r_tx_start;
  logic [7:0]  r_tx_byte;
  logic [31:0] r_count;
  logic [15:0] r_err;
  logic        r_recv_done;
  logic        r_send_done;
  logic [3:0]  r_result;
  logic        r_busy_seen;

  // Packet decode: the third byte is used straight off the receive port so
  // the check and the write happen on the same edge that accepts it.
  logic [23:0] w_pkt;
  logic [9:0]  w_loc;
  logic [7:0]  w_data;
  logic [2:0]  w_foot;
  logic [2:0]  w_foot_exp;
  logic        w_pkt_ok;
  logic        w_timeout;
  logic [1:0]  w_eff_idx;
  logic        w_img_full;
  logic        w_cpu_owns;

  assign w_pkt      = {r_b0, r_b1, rx_byte};
  assign w_loc      = w_pkt[20:11];
  assign w_data     = w_pkt[10:3];
  assign w_foot     = w_pkt[2:0];
  assign w_foot_exp = {^w_data, ^w_loc, ^{w_data[7:4], w_loc[9:5]}};
  assign w_pkt_ok   = (w_foot == w_foot_exp) && ({22'd0, w_loc} < C_NUM_PIXELS);

  // r_tmo counts idle cycles since the last byte; a gap strictly longer than
  // TIMEOUT abandons the partial packet. A byte arriving in the expiry cycle
  // is re-interpreted as the first byte of a new packet.
  assign w_timeout  = (r_idx != 2'd0) && (r_tmo > TIMEOUT);
  assign w_eff_idx  = w_timeout ? 2'd0 : r_idx;
  assign w_img_full = (r_count == C_NUM_PIXELS);

  // Only RUN gives the CPU the RAM; SEND/WAIT_TX keep the loader (idle) side.
  assign w_cpu_owns  = (r_state == ST_RUN);
  assign ram_addr    = w_cpu_owns ? cpu_ram_addr : r_ld_addr;
  assign ram_data_in = w_cpu_owns ? cpu_ram_data : r_ld_data;
  assign ram_we      = w_cpu_owns ? cpu_ram_we   : r_ld_we;

  assign cpu_run       = r_cpu_run;
  assign tx_start      = r_tx_start;
  assign tx_byte       = r_tx_byte;
  assign count_packets = r_count;
  assign err_count     = r_err;
  assign receive_done  = r_recv_done;
  assign send_done     = r_send_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_LOAD;
      r_idx       <= 2'd0;
      r_b0        <= 8'd0;
      r_b1        <= 8'd0;
      r_tmo       <= 16'd0;
      r_ld_addr   <= 14'd0;
      r_ld_data   <= 24'd0;
      r_ld_we     <= 4'd0;
      r_cpu_run   <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_byte   <= 8'd0;
      r_count     <= 32'd0;
      r_err       <= 16'd0;
      r_recv_done <= 1'b0;
      r_send_done <= 1'b0;
      r_result    <= 4'd0;
      r_busy_seen <= 1'b0;
    end else begin
      r_ld_we     <= 4'd0;
      r_tx_start  <= 1'b0;
      r_send_done <= 1'b0;

      case (r_state)
        ST_LOAD: begin
          if (w_img_full) begin
            // Image complete: hand over before any further byte is consumed.
            r_recv_done <= 1'b1;
            r_cpu_run   <= 1'b1;
            r_idx       <= 2'd0;
            r_tmo       <= 16'd0;
            r_state     <= ST_RUN;
          end else if (rx_valid) begin
            r_tmo <= 16'd0;
            case (w_eff_idx)
              2'd0: begin
                if (rx_byte[7:5] == HEADER) begin
                  r_b0  <= rx_byte;
                  r_idx <= 2'd1;
                end else begin
                  r_idx <= 2'd0;
                end
              end
              2'd1: begin
                r_b1  <= rx_byte;
                r_idx <= 2'd2;
              end
              default: begin
                r_idx <= 2'd0;
                if (w_pkt_ok) begin
                  r_ld_addr <= IMG_BASE + {4'd0, w_loc};
                  r_ld_data <= {16'h0000, w_data};
                  r_ld_we   <= 4'b1111;
                  r_count   <= r_count + 32'd1;
                end else if (r_err != 16'hFFFF) begin
                  r_err <= r_err + 16'd1;
                end
              end
            endcase
          end else if (r_idx != 2'd0) begin
            if (w_timeout) begin
              r_idx <= 2'd0;
              r_tmo <= 16'd0;
            end else if (r_tmo != 16'hFFFF) begin
              r_tmo <= r_tmo + 16'd1;
            end
          end
        end

        ST_RUN: begin
          if (cpu_halt) begin
            r_result <= nn_result;
            r_state  <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!tx_busy) begin
            r_tx_start  <= 1'b1;
            r_tx_byte   <= 8'h30 + {4'h0, r_result};
            r_busy_seen <= 1'b0;
            r_state     <= ST_WAIT_TX;
          end
        end

        default: begin
          // Wait for the transmitter to pick up the byte and then go idle.
          if (tx_busy) begin
            r_busy_seen <= 1'b1;
          end else if (r_busy_seen) begin
            r_busy_seen <= 1'b0;
            r_send_done <= 1'b1;
            r_count     <= 32'd0;
            r_recv_done <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
